// File: rtl/prof_dump_tx.sv
// prof_dump_tx: snapshots a bank of 2*XLEN-bit profiling counters and
// streams them out as a byte frame over a valid/ready byte channel.
//
// Frame: 0xA5, N_CNT, counters 0..N_CNT-1 (each BPC bytes, little-endian,
// zero-padded in the MSBs), XOR checksum of all preceding bytes.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      async active-low reset
//   cnt_i       flat counter bank, counter k at [k*2*XLEN +: 2*XLEN]
//   dump_req_i  level-sampled request; honoured only in IDLE
//   tx_data_o   current frame byte (0x00 when idle)
//   tx_valid_o  tx_data_o holds a valid byte
//   tx_ready_i  sink accepts the byte this edge
//   busy_o      frame in progress
//   done_o      one-cycle pulse after the checksum byte transfers
//   overrun_o   sticky: a request arrived while not idle
module prof_dump_tx #(
  parameter int XLEN  = 32,
  parameter int N_CNT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_CNT*2*XLEN-1:0] cnt_i,
  input  logic                    dump_req_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);

  localparam int CW  = 2 * XLEN;
  localparam int BPC = (CW + 7) / 8;                    // bytes per counter
  localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CIW = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam logic [BW-1:0]  LAST_B = BW'(BPC - 1);
  localparam logic [CIW-1:0] LAST_C = CIW'(N_CNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_CSUM} state_t;

  state_t                   state_q, state_d;
  logic [N_CNT-1:0][CW-1:0] shadow_q;
  logic [BW-1:0]            bidx_q;
  logic [CIW-1:0]           cidx_q;
  logic [7:0]               csum_q;
  logic                     done_q, ovr_q;
  logic [BPC*8-1:0]         word;
  logic [7:0]               data_byte;
  logic                     xfer, start;

  // Current counter zero-extended to a whole number of bytes.
  always_comb begin
    word           = '0;
    word[CW-1:0]   = shadow_q[cidx_q];
    data_byte      = word[{bidx_q, 3'b000} +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state_q)
      S_IDLE: if (dump_req_i) state_d = S_HDR;
      S_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'hA5;
        if (tx_ready_i) state_d = S_LEN;
      end
      S_LEN: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'(N_CNT);
        if (tx_ready_i) state_d = S_DATA;
      end
      S_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = data_byte;
        if (tx_ready_i && bidx_q == LAST_B && cidx_q == LAST_C) state_d = S_CSUM;
      end
      S_CSUM: begin
        tx_valid_o = 1'b1;
        tx_data_o  = csum_q;
        if (tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer  = tx_valid_o && tx_ready_i;
  assign start = (state_q == S_IDLE) && dump_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      bidx_q   <= '0;
      cidx_q   <= '0;
      csum_q   <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (start) begin
        shadow_q <= cnt_i;
        bidx_q   <= '0;
        cidx_q   <= '0;
        csum_q   <= '0;
      end
      // Checksum folds in every byte that actually transfers, header included.
      if (xfer && state_q != S_CSUM) csum_q <= csum_q ^ tx_data_o;
      if (xfer && state_q == S_DATA) begin
        if (bidx_q == LAST_B) begin
          bidx_q <= '0;
          cidx_q <= (cidx_q == LAST_C) ? '0 : cidx_q + 1'b1;
        end else begin
          bidx_q <= bidx_q + 1'b1;
        end
      end
      done_q <= xfer && (state_q == S_CSUM);
      // Any request seen while a frame is active (including the CSUM edge) is dropped.
      if (dump_req_i && state_q != S_IDLE) ovr_q <= 1'b1;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign overrun_o = ovr_q;

endmodule

// File: doc/prof_dump_tx.md
PROF_DUMP_TX -- requirements
Module: prof_dump_tx

Interface
REQ-001 SHALL have parameter XLEN, default 32: base word width; each counter is 2*XLEN bits wide.
REQ-002 SHALL have parameter N_CNT, default 8: number of counters dumped, legal range 1..16.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cnt_i  input  N_CNT*2*XLEN  flat counter bank; counter k occupies bits [k*2*XLEN +: 2*XLEN].
REQ-006 SHALL have port dump_req_i  input  1  request to snapshot the bank and transmit one frame.
REQ-007 SHALL have port tx_data_o  output  8  current frame byte.
REQ-008 SHALL have port tx_valid_o  output  1  tx_data_o holds a valid byte.
REQ-009 SHALL have port tx_ready_i  input  1  sink accepts the byte; a transfer occurs on any edge where tx_valid_o and tx_ready_i are both 1.
REQ-010 SHALL have port busy_o  output  1  a frame is in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse, frame complete.
REQ-012 SHALL have port overrun_o  output  1  sticky flag, a request was dropped.

Function
REQ-013 SHALL implement states IDLE, HDR, LEN, DATA, CSUM.
REQ-014 In IDLE with dump_req_i=1 at an edge, SHALL copy all of cnt_i into internal shadow registers at that edge and enter HDR.
REQ-015 SHALL drive tx_valid_o=1 and busy_o=1 in HDR, LEN, DATA and CSUM; tx_valid_o SHALL be 0 in IDLE.
REQ-016 First byte SHALL reach tx_valid_o in the cycle right after the request edge (1-cycle latency).
REQ-017 Frame byte order SHALL be: 0xA5 (HDR), N_CNT as an 8-bit value (LEN), counters 0..N_CNT-1 each 8 bytes little-endian (DATA), checksum (CSUM); total bytes = 3 + 8*N_CNT.
REQ-018 With XLEN other than 32, each counter SHALL be sent as ceil(2*XLEN/8) bytes, zero-padded in the MSBs.
REQ-019 Checksum SHALL be the XOR of every preceding byte of the frame, including 0xA5 and the LEN byte.
REQ-020 SHALL advance one byte per transfer; while tx_ready_i=0, tx_data_o and tx_valid_o SHALL hold stable.
REQ-021 Byte index within a counter SHALL be a 3-bit counter wrapping 7->0; on that wrap the counter index SHALL increment; after byte 7 of counter N_CNT-1 the state SHALL go to CSUM.
REQ-022 On the CSUM transfer, SHALL go to IDLE and pulse done_o for exactly the following cycle; busy_o SHALL be 0 in that cycle.
REQ-023 Changes on cnt_i after the snapshot edge SHALL NOT affect the frame in progress.
REQ-024 dump_req_i=1 on any edge outside IDLE SHALL be ignored for framing and SHALL set overrun_o; overrun_o SHALL clear only by reset.
REQ-025 dump_req_i=1 on the same edge as the CSUM transfer SHALL count as an overrun; no new frame SHALL start.
REQ-026 A new frame SHALL start no earlier than the edge after done_o is asserted; back-to-back frames are legal.
REQ-027 dump_req_i SHALL be level-sampled, not edge-detected; a request held high through done_o SHALL start the next frame from IDLE and SHALL also set overrun_o for the cycles it was held while busy.

Reset
REQ-028 rst_ni=0 SHALL immediately force state IDLE, tx_valid_o=0, tx_data_o=0x00, busy_o=0, done_o=0, overrun_o=0, and clear shadow registers, indices and checksum, independent of clk_i.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done_o; the first request after release SHALL start a complete new frame from 0xA5.

Verification
REQ-030 N_CNT=2, cnt0=0x0102030405060708, cnt1=0, tx_ready_i=1, one request pulse -> 19 consecutive bytes A5 02 08 07 06 05 04 03 02 01 00x8 AF, then done_o pulse one cycle.
REQ-031 Same frame with tx_ready_i=0 for 3 cycles while byte 0x06 is presented -> 0x06 held stable with tx_valid_o=1 for 4 cycles, byte sequence unchanged.
REQ-032 Change cnt0 to 0xFFFF_FFFF_FFFF_FFFF one cycle after the request -> transmitted frame still carries 0x0102030405060708 and checksum 0xAF.
REQ-033 Pulse dump_req_i during the DATA state -> overrun_o=1 and stays 1; the frame is unchanged; exactly one done_o.
REQ-034 Drop rst_ni between clock edges during byte 5 -> tx_valid_o and busy_o go to 0 without a clock edge; the next request yields a full 19-byte frame starting 0xA5.
REQ-035 N_CNT=1, all-ones counter -> A5 01 FF x8, checksum 0xA4, 11 bytes total.
